difftest_commit_queue: RTL and testbench

- Parametrised multi-slot commit buffer between the core's writeback stage and the difftest DPI modules (InstrCommit, TrapEvent).
- Accepts up to NR_COMMIT retiring instructions per cycle, compacts them in program order into a FIFO, and drains up to NR_COMMIT per cycle as registered commit records.
- Detects the good/bad trap instruction, latches the trap code, and maintains cycle and instruction counters.
- Supersedes the single-slot commit register logic in the simulation top.

---
 rtl/difftest_commit_queue_if.sv | 39 +++
 rtl/difftest_commit_queue.sv | 152 +++++++++++++++
 tb/tb_difftest_commit_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/difftest_commit_queue_if.sv
// Interface between the core writeback stage, the difftest commit queue and its consumers.
// The producer side (master) drives retire slots and drain permission; the queue (slave) drives commit records.
interface difftest_commit_queue_if #(
  parameter int NR_COMMIT = 2,
  parameter int XLEN      = 64
);
  logic [NR_COMMIT-1:0]      wb_valid;
  logic [NR_COMMIT*XLEN-1:0] wb_pc;
  logic [NR_COMMIT*32-1:0]   wb_inst;
  logic [NR_COMMIT-1:0]      wb_rf_we;
  logic [NR_COMMIT*5-1:0]    wb_rf_wnum;
  logic [NR_COMMIT*XLEN-1:0] wb_rf_wdata;
  logic [XLEN-1:0]           a0_value;
  logic                      wb_ready;
  logic                      drain_en;
  logic [NR_COMMIT-1:0]      cmt_valid;
  logic [NR_COMMIT*XLEN-1:0] cmt_pc;
  logic [NR_COMMIT*32-1:0]   cmt_inst;
  logic [NR_COMMIT*XLEN-1:0] cmt_wdata;
  logic [NR_COMMIT-1:0]      cmt_wen;
  logic [NR_COMMIT*8-1:0]    cmt_wdest;
  logic                      trap;
  logic [7:0]                trap_code;
  logic [XLEN-1:0]           trap_pc;
  logic [63:0]               cycle_cnt;
  logic [63:0]               instr_cnt;

  modport master (
    output wb_valid, wb_pc, wb_inst, wb_rf_we, wb_rf_wnum, wb_rf_wdata, a0_value, drain_en,
    input  wb_ready, cmt_valid, cmt_pc, cmt_inst, cmt_wdata, cmt_wen, cmt_wdest,
           trap, trap_code, trap_pc, cycle_cnt, instr_cnt
  );

  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_rf_we, wb_rf_wnum, wb_rf_wdata, a0_value, drain_en,
    output wb_ready, cmt_valid, cmt_pc, cmt_inst, cmt_wdata, cmt_wen, cmt_wdest,
           trap, trap_code, trap_pc, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/difftest_commit_queue.sv
// Multi-slot commit FIFO between writeback and the difftest models: compacts retiring
// slots in program order, drains up to NR_COMMIT registered records per cycle, stops at a trap.
module difftest_commit_queue #(
  parameter int         NR_COMMIT   = 2,
  parameter int         DEPTH       = 8,
  parameter int         XLEN        = 64,
  parameter logic [6:0] TRAP_OPCODE = 7'h6b
) (
  input  logic                   clock,
  input  logic                   reset,
  difftest_commit_queue_if.slave cq
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     inst_mem  [DEPTH];
  logic            wen_mem   [DEPTH];
  logic [4:0]      wnum_mem  [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];
  logic            trap_mem  [DEPTH];
  logic [7:0]      code_mem  [DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q, count_q;
  logic [PW-1:0] n_enq, n_deq;
  logic [AW-1:0] wpos [NR_COMMIT];
  logic [AW-1:0] ridx;
  logic          enq_en, deq_en, stop;

  logic [NR_COMMIT-1:0]      cmt_valid_q, cmt_valid_d, cmt_wen_q, cmt_wen_d;
  logic [NR_COMMIT*XLEN-1:0] cmt_pc_q, cmt_pc_d, cmt_wdata_q, cmt_wdata_d;
  logic [NR_COMMIT*32-1:0]   cmt_inst_q, cmt_inst_d;
  logic [NR_COMMIT*8-1:0]    cmt_wdest_q, cmt_wdest_d;
  logic                      trap_q, trap_d;
  logic [7:0]                trap_code_q, trap_code_d;
  logic [XLEN-1:0]           trap_pc_q, trap_pc_d;
  logic [63:0]               cycle_cnt_q, instr_cnt_q;

  // Ready depends only on registered occupancy, never on this cycle's drain
  assign cq.wb_ready = !reset && (count_q <= PW'(DEPTH - NR_COMMIT));
  assign enq_en      = cq.wb_ready && !trap_q;
  assign deq_en      = cq.drain_en && !trap_q;

  always_comb begin
    n_enq = '0;
    for (int i = 0; i < NR_COMMIT; i++) begin
      wpos[i] = AW'(wr_ptr_q + n_enq);
      if (enq_en && cq.wb_valid[i]) n_enq = n_enq + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NR_COMMIT; i++) begin
      if (enq_en && cq.wb_valid[i]) begin
        pc_mem[wpos[i]]    <= cq.wb_pc[i*XLEN +: XLEN];
        inst_mem[wpos[i]]  <= cq.wb_inst[i*32 +: 32];
        wen_mem[wpos[i]]   <= cq.wb_rf_we[i] && (cq.wb_rf_wnum[i*5 +: 5] != 5'd0);
        wnum_mem[wpos[i]]  <= cq.wb_rf_wnum[i*5 +: 5];
        wdata_mem[wpos[i]] <= cq.wb_rf_wdata[i*XLEN +: XLEN];
        trap_mem[wpos[i]]  <= (cq.wb_inst[i*32 +: 7] == TRAP_OPCODE);
        code_mem[wpos[i]]  <= (cq.wb_inst[i*32 +: 7] == TRAP_OPCODE) ? cq.a0_value[7:0] : 8'd0;
      end
    end
  end

  // Pop oldest-first; the group is cut right after the first trap entry
  always_comb begin
    n_deq       = '0;
    stop        = 1'b0;
    ridx        = '0;
    cmt_valid_d = '0;
    cmt_pc_d    = '0;
    cmt_inst_d  = '0;
    cmt_wen_d   = '0;
    cmt_wdest_d = '0;
    cmt_wdata_d = '0;
    trap_d      = trap_q;
    trap_code_d = trap_code_q;
    trap_pc_d   = trap_pc_q;
    if (deq_en) begin
      for (int i = 0; i < NR_COMMIT; i++) begin
        if (!stop && (PW'(i) < count_q)) begin
          ridx                         = AW'(rd_ptr_q + PW'(i));
          cmt_valid_d[i]               = 1'b1;
          cmt_pc_d[i*XLEN +: XLEN]     = pc_mem[ridx];
          cmt_inst_d[i*32 +: 32]       = inst_mem[ridx];
          cmt_wen_d[i]                 = wen_mem[ridx];
          cmt_wdest_d[i*8 +: 8]        = {3'b000, wnum_mem[ridx]};
          cmt_wdata_d[i*XLEN +: XLEN]  = wdata_mem[ridx];
          n_deq                        = n_deq + PW'(1);
          if (trap_mem[ridx]) begin
            stop        = 1'b1;
            trap_d      = 1'b1;
            trap_code_d = code_mem[ridx];
            trap_pc_d   = pc_mem[ridx];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cmt_valid_q <= '0;
      cmt_pc_q    <= '0;
      cmt_inst_q  <= '0;
      cmt_wen_q   <= '0;
      cmt_wdest_q <= '0;
      cmt_wdata_q <= '0;
      trap_q      <= 1'b0;
      trap_code_q <= '0;
      trap_pc_q   <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_q + n_deq;
      wr_ptr_q    <= wr_ptr_q + n_enq;
      count_q     <= count_q + n_enq - n_deq;
      cmt_valid_q <= cmt_valid_d;
      cmt_pc_q    <= cmt_pc_d;
      cmt_inst_q  <= cmt_inst_d;
      cmt_wen_q   <= cmt_wen_d;
      cmt_wdest_q <= cmt_wdest_d;
      cmt_wdata_q <= cmt_wdata_d;
      trap_q      <= trap_d;
      trap_code_q <= trap_code_d;
      trap_pc_q   <= trap_pc_d;
      if (!trap_q) cycle_cnt_q <= cycle_cnt_q + 64'd1;
      instr_cnt_q <= instr_cnt_q + 64'(n_deq);
    end
  end

  // Retiring while not ready is a core protocol error; those slots are lost
  always_ff @(posedge clock) begin
    if (!reset) assert (!((|cq.wb_valid) && !cq.wb_ready));
  end

  assign cq.cmt_valid = cmt_valid_q;
  assign cq.cmt_pc    = cmt_pc_q;
  assign cq.cmt_inst  = cmt_inst_q;
  assign cq.cmt_wen   = cmt_wen_q;
  assign cq.cmt_wdest = cmt_wdest_q;
  assign cq.cmt_wdata = cmt_wdata_q;
  assign cq.trap      = trap_q;
  assign cq.trap_code = trap_code_q;
  assign cq.trap_pc   = trap_pc_q;
  assign cq.cycle_cnt = cycle_cnt_q;
  assign cq.instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue (NR_COMMIT=2, DEPTH=8, XLEN=64).
module tb_difftest_commit_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [63:0] exp_cycles = '0;
  bit   frozen = 1'b0;

  always #5 clock = ~clock;

  difftest_commit_queue_if #(.NR_COMMIT(2), .XLEN(64)) cq ();

  difftest_commit_queue #(
    .NR_COMMIT(2), .DEPTH(8), .XLEN(64), .TRAP_OPCODE(7'h6b)
  ) dut (
    .clock (clock),
    .reset (reset),
    .cq    (cq.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle; track the expected cycle counter
  task automatic tick();
    bit rst_at_edge;
    rst_at_edge = reset;
    @(posedge clock);
    #1;
    if (rst_at_edge) exp_cycles = '0;
    else if (!frozen) exp_cycles = exp_cycles + 64'd1;
  endtask

  task automatic idle_slots();
    cq.wb_valid    = 2'b00;
    cq.wb_pc       = '0;
    cq.wb_inst     = '0;
    cq.wb_rf_we    = '0;
    cq.wb_rf_wnum  = '0;
    cq.wb_rf_wdata = '0;
    cq.a0_value    = '0;
  endtask

  task automatic drive2(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                        input logic [31:0] in0, input logic [31:0] in1);
    cq.wb_valid    = v;
    cq.wb_pc       = {pc1, pc0};
    cq.wb_inst     = {in1, in0};
    cq.wb_rf_we    = 2'b00;
    cq.wb_rf_wnum  = '0;
    cq.wb_rf_wdata = '0;
  endtask

  initial begin
    idle_slots();
    cq.drain_en = 1'b1;

    // Reset held with retire slots active
    reset = 1'b1;
    cq.wb_valid = 2'b11;
    cq.wb_inst  = {32'h00000013, 32'h00000013};
    for (int i = 0; i < 3; i++) tick();
    check("rst_ready", 64'(cq.wb_ready), 64'd0);
    check("rst_cmt_valid", 64'(cq.cmt_valid), 64'd0);
    check("rst_trap", 64'(cq.trap), 64'd0);
    check("rst_cycle", cq.cycle_cnt, 64'd0);
    check("rst_instr", cq.instr_cnt, 64'd0);
    reset = 1'b0;
    idle_slots();
    #1;
    check("ready_after_rst", 64'(cq.wb_ready), 64'd1);
    tick();
    check("nothing_queued", 64'(cq.cmt_valid), 64'd0);
    check("cycle_first", cq.cycle_cnt, exp_cycles);

    // Single slot addi x1,x0,1
    cq.wb_valid    = 2'b01;
    cq.wb_pc       = {64'd0, 64'h80000000};
    cq.wb_inst     = {32'd0, 32'h00100093};
    cq.wb_rf_we    = 2'b01;
    cq.wb_rf_wnum  = {5'd0, 5'd1};
    cq.wb_rf_wdata = {64'd0, 64'd1};
    tick();
    idle_slots();
    check("single_not_yet", 64'(cq.cmt_valid), 64'd0);
    tick();
    check("single_valid", 64'(cq.cmt_valid), 64'h1);
    check("single_pc", cq.cmt_pc[63:0], 64'h80000000);
    check("single_inst", 64'(cq.cmt_inst[31:0]), 64'h00100093);
    check("single_wen", 64'(cq.cmt_wen), 64'h1);
    check("single_wdest", 64'(cq.cmt_wdest[7:0]), 64'h1);
    check("single_wdata", cq.cmt_wdata[63:0], 64'h1);
    check("single_slot1_pc", cq.cmt_pc[127:64], 64'h0);
    check("single_instr", cq.instr_cnt, 64'd1);
    tick();
    check("single_drained", 64'(cq.cmt_valid), 64'd0);

    // Hole in slot 0, slot 1 writes x0
    cq.wb_valid    = 2'b10;
    cq.wb_pc       = {64'h80000004, 64'hdead};
    cq.wb_inst     = {32'h00000013, 32'h00000013};
    cq.wb_rf_we    = 2'b11;
    cq.wb_rf_wnum  = {5'd0, 5'd3};
    cq.wb_rf_wdata = {64'h55, 64'h77};
    tick();
    idle_slots();
    tick();
    check("hole_valid", 64'(cq.cmt_valid), 64'h1);
    check("hole_pc", cq.cmt_pc[63:0], 64'h80000004);
    check("hole_wen_x0", 64'(cq.cmt_wen), 64'h0);
    check("hole_wdest", 64'(cq.cmt_wdest[7:0]), 64'h0);
    check("hole_wdata", cq.cmt_wdata[63:0], 64'h55);
    check("hole_instr", cq.instr_cnt, 64'd2);

    // Backpressure: fill 8 entries with drain disabled
    cq.drain_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("bp_ready_fill", 64'(cq.wb_ready), 64'd1);
      drive2(2'b11, 64'h100 + 64'(c * 8), 64'h104 + 64'(c * 8), 32'h00000013, 32'h00000013);
      tick();
    end
    idle_slots();
    check("bp_full_ready", 64'(cq.wb_ready), 64'd0);
    check("bp_no_commit", 64'(cq.cmt_valid), 64'd0);
    cq.drain_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_valid", 64'(cq.cmt_valid), 64'h3);
      check("bp_pc0", cq.cmt_pc[63:0], 64'h100 + 64'(c * 8));
      check("bp_pc1", cq.cmt_pc[127:64], 64'h104 + 64'(c * 8));
      if (c == 0) check("bp_ready_at6", 64'(cq.wb_ready), 64'd1);
    end
    check("bp_instr", cq.instr_cnt, 64'd10);
    tick();
    check("bp_empty", 64'(cq.cmt_valid), 64'd0);

    // Good trap in slot 0, slot 1 must never commit
    drive2(2'b11, 64'h200, 64'h204, 32'h0000006b, 32'h00000013);
    cq.a0_value = 64'h0;
    tick();
    idle_slots();
    tick();
    frozen = 1'b1;
    check("trap_valid", 64'(cq.cmt_valid), 64'h1);
    check("trap_flag", 64'(cq.trap), 64'd1);
    check("trap_code", 64'(cq.trap_code), 64'h0);
    check("trap_pc", cq.trap_pc, 64'h200);
    check("trap_cmt_pc", cq.cmt_pc[63:0], 64'h200);
    check("trap_instr", cq.instr_cnt, 64'd11);
    for (int c = 0; c < 3; c++) tick();
    check("trap_frozen_valid", 64'(cq.cmt_valid), 64'd0);
    check("trap_sticky", 64'(cq.trap), 64'd1);
    check("trap_cycle_hold", cq.cycle_cnt, exp_cycles);
    check("trap_instr_hold", cq.instr_cnt, 64'd11);

    // Bad trap after a fresh reset, then reset clears it
    reset = 1'b1;
    tick();
    tick();
    check("rst2_trap", 64'(cq.trap), 64'd0);
    check("rst2_cycle", cq.cycle_cnt, 64'd0);
    reset  = 1'b0;
    frozen = 1'b0;
    drive2(2'b01, 64'h300, 64'h0, 32'h0000006b, 32'h0);
    cq.a0_value = 64'h5;
    tick();
    idle_slots();
    tick();
    frozen = 1'b1;
    check("bad_trap_flag", 64'(cq.trap), 64'd1);
    check("bad_trap_code", 64'(cq.trap_code), 64'h05);
    check("bad_trap_pc", cq.trap_pc, 64'h300);
    check("bad_trap_cycle", cq.cycle_cnt, exp_cycles);
    check("bad_trap_instr", cq.instr_cnt, 64'd1);
    reset = 1'b1;
    tick();
    check("rst3_trap", 64'(cq.trap), 64'd0);
    check("rst3_cycle", cq.cycle_cnt, 64'd0);
    check("rst3_instr", cq.instr_cnt, 64'd0);
    check("rst3_code", 64'(cq.trap_code), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
